// File: rtl/if_id_skid_buffer.sv
// ---------------------------------------------------------------------------
// if_id_skid_buffer
//   Two-entry elastic pipeline register between fetch and decode. Entries of
//   {instruction, PC, PC+4} are accepted from fetch with a valid/ready
//   handshake and presented to decode in strict FIFO order. Every output is
//   a register, so there is no combinational path from in_* to out_* or
//   from out_ready to in_ready. A flush discards all held entries together
//   with any push or pop in the same cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset (0 = reset)
//   in_valid       fetch offers an entry
//   in_ready       buffer can accept an entry (state != FULL)
//   in_instr       fetched instruction
//   in_pc          PC of in_instr
//   in_pc_plus_4   in_pc + 4
//   flush          drop all held entries and any same-cycle push/pop
//   out_valid      head entry valid toward decode
//   out_ready      decode consumes the head entry
//   out_instr      head instruction, NOP_INSTR when out_valid=0
//   out_pc         head PC, 0 when out_valid=0
//   out_pc_plus_4  head PC+4, 0 when out_valid=0
//   occupancy      number of held entries (0..2)
//   stall_count    saturating count of cycles where fetch was refused
//                  (only when IFID_STALL_CNT_EN is defined)
//
// Build option
//   IFID_STALL_CNT_EN  adds parameter CNT_W, port stall_count and its counter.
// ---------------------------------------------------------------------------
module if_id_skid_buffer #(
    parameter int unsigned  W         = 32,
    parameter logic [W-1:0] NOP_INSTR = '0
`ifdef IFID_STALL_CNT_EN
    ,
    parameter int unsigned  CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_instr,
    input  logic [W-1:0]     in_pc,
    input  logic [W-1:0]     in_pc_plus_4,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_instr,
    output logic [W-1:0]     out_pc,
    output logic [W-1:0]     out_pc_plus_4,
    output logic [1:0]       occupancy
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    // Encoding equals the number of held entries, so occupancy is a cast.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e       state_q;
    state_e       state_d;
    logic         wr_ptr_q;
    logic         wr_ptr_d;
    logic         rd_ptr_q;
    logic         rd_ptr_d;
    logic         push;
    logic         pop;

    logic [W-1:0] instr_q [2];
    logic [W-1:0] pc_q    [2];
    logic [W-1:0] pc4_q   [2];

    logic [W-1:0] head_instr_d;
    logic [W-1:0] head_pc_d;
    logic [W-1:0] head_pc4_d;

    // Next FSM state; flush wins over any push/pop.
    function automatic state_e next_state(input state_e s, input logic psh,
                                          input logic pp, input logic fl);
        state_e n;
        n = s;
        if (fl) begin
            n = S_EMPTY;
        end else begin
            case (s)
                S_EMPTY: if (psh) n = S_ONE;
                S_ONE: begin
                    if (psh && !pp)      n = S_FULL;
                    else if (pp && !psh) n = S_EMPTY;
                end
                S_FULL:  if (pp) n = S_ONE;
                default: n = S_EMPTY;
            endcase
        end
        return n;
    endfunction

    // Handshakes use the registered ready/valid, which mirror the state.
    always_comb begin
        push     = in_valid & in_ready & ~flush;
        pop      = out_valid & out_ready & ~flush;
        state_d  = next_state(state_q, push, pop, flush);
        wr_ptr_d = flush ? 1'b0 : (wr_ptr_q ^ push);
        rd_ptr_d = flush ? 1'b0 : (rd_ptr_q ^ pop);
    end

    // Head after this edge: the incoming entry bypasses storage when it
    // lands in the slot the read pointer will point at (push into EMPTY, or
    // push+pop in ONE), otherwise the stored entry at the new read pointer.
    always_comb begin
        head_instr_d = instr_q[rd_ptr_d];
        head_pc_d    = pc_q[rd_ptr_d];
        head_pc4_d   = pc4_q[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_instr_d = in_instr;
            head_pc_d    = in_pc;
            head_pc4_d   = in_pc_plus_4;
        end
    end

    // FSM, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_EMPTY;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_instr     <= NOP_INSTR;
            out_pc        <= '0;
            out_pc_plus_4 <= '0;
            occupancy     <= 2'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            in_ready  <= (state_d != S_FULL);
            out_valid <= (state_d != S_EMPTY);
            occupancy <= 2'(state_d);
            if (state_d != S_EMPTY) begin
                out_instr     <= head_instr_d;
                out_pc        <= head_pc_d;
                out_pc_plus_4 <= head_pc4_d;
            end else begin
                out_instr     <= NOP_INSTR;
                out_pc        <= '0;
                out_pc_plus_4 <= '0;
            end
        end
    end

    // Payload storage; stale slots are masked by the output registers.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_q[wr_ptr_q] <= in_instr;
            pc_q[wr_ptr_q]    <= in_pc;
            pc4_q[wr_ptr_q]   <= in_pc_plus_4;
        end
    end

`ifdef IFID_STALL_CNT_EN
    // Saturating count of refused fetch cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
module tb_if_id_skid_buffer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_instr;
    logic [W-1:0] in_pc;
    logic [W-1:0] in_pc_plus_4;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_instr;
    logic [W-1:0] out_pc;
    logic [W-1:0] out_pc_plus_4;
    logic [1:0]   occupancy;
`ifdef IFID_STALL_CNT_EN
    logic [15:0]  stall_count;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_out_instr;
    logic [W-1:0] s_out_pc;
    logic [W-1:0] s_out_pc_plus_4;
    logic [1:0]   s_occupancy;
    logic [1:0]   s_stall_count;
`endif

    always #5 clk = ~clk;

    if_id_skid_buffer #(.W(W), .NOP_INSTR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_pc_plus_4  (in_pc_plus_4),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus_4 (out_pc_plus_4),
        .occupancy     (occupancy)
`ifdef IFID_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

`ifdef IFID_STALL_CNT_EN
    // Narrow-counter copy driven by the same stimulus, for saturation.
    if_id_skid_buffer #(.W(W), .NOP_INSTR(32'h0000_0000), .CNT_W(2)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_pc_plus_4  (in_pc_plus_4),
        .flush         (flush),
        .out_valid     (s_out_valid),
        .out_ready     (out_ready),
        .out_instr     (s_out_instr),
        .out_pc        (s_out_pc),
        .out_pc_plus_4 (s_out_pc_plus_4),
        .occupancy     (s_occupancy),
        .stall_count   (s_stall_count)
    );
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    typedef struct {
        bit          rst_n;
        bit          v;
        logic [31:0] pc;
        bit          rdy;
        bit          fl;
        int          occ;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h2008_0005 + (pc << 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Compare DUT outputs with the scoreboard head / fill level.
    task automatic check_outputs();
        chk("occupancy", 32'(occupancy), 32'(sb.size()));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk("out_instr", out_instr, sb[0].instr);
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_pc_plus_4", out_pc_plus_4, sb[0].pc4);
        end else begin
            chk("idle_instr", out_instr, 32'h0000_0000);
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_pc_plus_4", out_pc_plus_4, 32'h0);
        end
    endtask

    // Drive one cycle, update the scoreboard, clock, then check.
    task automatic step(input bit rst_n, input bit v, input logic [31:0] pc,
                        input bit rdy, input bit fl);
        ent_t e;
        bit   take;
        bit   give;
        reset        = rst_n;
        in_valid     = v;
        in_pc        = pc;
        in_instr     = instr_of(pc);
        in_pc_plus_4 = pc + 32'd4;
        out_ready    = rdy;
        flush        = fl;
        e = '{instr_of(pc), pc, pc + 32'd4};
        if (!rst_n || fl) begin
            sb.delete();
        end else begin
            take = v && (sb.size() < 2);
            give = (sb.size() > 0) && rdy;
            if (give) void'(sb.pop_front());
            if (take) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic add(input bit r, input bit v, input logic [31:0] pc,
                       input bit rdy, input bit fl, input int occ);
        vec_t t;
        t = '{r, v, pc, rdy, fl, occ};
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        in_pc_plus_4 = '0; flush = 1'b0; out_ready = 1'b0;

        // rst_n, valid, pc, out_ready, flush, occupancy after the edge
        add(0, 1, 32'h40, 0, 0, 0);  // reset with valid offered
        add(0, 1, 32'h40, 0, 0, 0);
        add(1, 1, 32'h00, 1, 0, 1);  // single pass
        add(1, 0, 32'h00, 1, 0, 0);
        add(1, 1, 32'h00, 0, 0, 1);  // fill
        add(1, 1, 32'h04, 0, 0, 2);
        add(1, 1, 32'h08, 0, 0, 2);  // refused while full
        add(1, 1, 32'h08, 1, 0, 1);  // pop 0x0, 0x8 still refused
        add(1, 1, 32'h08, 1, 0, 1);  // pop 0x4, push 0x8
        add(1, 0, 32'h00, 1, 0, 0);
        add(1, 1, 32'h00, 1, 0, 1);  // stream, no bubbles
        add(1, 1, 32'h04, 1, 0, 1);
        add(1, 1, 32'h08, 1, 0, 1);
        add(1, 1, 32'h0C, 1, 0, 1);
        add(1, 0, 32'h00, 1, 0, 0);
        add(1, 1, 32'h10, 0, 0, 1);  // fill then flush with push
        add(1, 1, 32'h14, 0, 0, 2);
        add(1, 1, 32'h18, 0, 1, 0);
        add(1, 0, 32'h00, 1, 1, 0);  // flush while empty
        add(1, 1, 32'h20, 1, 0, 1);
        add(1, 0, 32'h00, 1, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
            chk($sformatf("tbl_occ[%0d]", i), 32'(occupancy), 32'(vecs[i].occ));
        end

        // Reset arriving mid-traffic beats a simultaneous flush and push.
        step(1, 1, 32'h30, 0, 0);
        step(0, 1, 32'h34, 1, 1);
        step(1, 0, 32'h00, 0, 0);

`ifdef IFID_STALL_CNT_EN
        step(0, 0, 32'h00, 0, 0);
        chk("stall_after_reset", 32'(stall_count), 32'd0);
        step(1, 1, 32'h00, 0, 0);
        step(1, 1, 32'h04, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 32'h08, 0, 0);
        chk("stall_five", 32'(stall_count), 32'd5);
        chk("stall_saturated", 32'(s_stall_count), 32'd3);
        step(1, 1, 32'h08, 0, 1);
        chk("stall_after_flush", 32'(stall_count), 32'd5);
        step(0, 1, 32'h08, 0, 0);
        chk("stall_cleared", 32'(stall_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
